// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one unified instruction/data memory between the multicycle core and
// the UART program loader. Accesses are serialised with a round-robin
// priority pointer. Read latency is tracked so that each requester sees a
// simple req/gnt/rvalid handshake.
//
// Handshake: a requester raises *_req together with *_we/*_addr/*_wdata and
// holds all four stable until it sees *_gnt high in the same cycle. The access
// is issued to memory in that grant cycle. A requester may drop *_req before a
// grant, and then no access is made. For a read, the requester's *_rvalid
// pulses for exactly one cycle MEM_LAT cycles after the grant, and *_rdata is
// valid only in that cycle. Writes produce no rvalid. No grant is given while
// a read is in flight.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   c_req/c_we/c_addr/c_wdata  core request
//   c_gnt/c_rvalid/c_rdata     core grant, read valid, read data
//   l_req/l_we/l_addr/l_wdata  loader request
//   l_gnt/l_rvalid/l_rdata     loader grant, read valid, read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   busy                       read in flight (state == WAIT, doubles as FSM state)
//   owner                      requester of last/current grant (0 core, 1 loader)
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [2:0] LAT_C = 3'(MEM_LAT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       prio_q, prio_d;
  logic       owner_q, owner_d;

  logic       winner;
  logic       any_req;
  logic       rvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  // A lone requester wins outright. Under contention the pointer decides.
  assign any_req = c_req | l_req;
  assign winner  = (c_req && l_req) ? prio_q : l_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    c_gnt     = 1'b0;
    l_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rvalid    = 1'b0;

    // Outputs are gated by reset so they drop asynchronously even while a
    // requester keeps its req high across the reset pulse.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            c_gnt     = ~winner;
            l_gnt     = winner;
            mem_en    = 1'b1;
            mem_we    = winner ? l_we    : c_we;
            mem_addr  = winner ? l_addr  : c_addr;
            mem_wdata = winner ? l_wdata : c_wdata;
            owner_d   = winner;
            prio_d    = ~winner;
            if (!mem_we) begin
              state_d = WAIT;
              cnt_d   = 3'd1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == LAT_C) begin
            rvalid  = 1'b1;
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign c_rvalid = rvalid & ~owner_q;
  assign l_rvalid = rvalid &  owner_q;
  assign c_rdata  = c_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;
  assign busy     = (state_q == WAIT);
  assign owner    = owner_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single unified instruction/data memory between the multicycle core's memory interface and the UART program loader. The core drives its port from its address mux and MemWrite/IRWrite sequencing. The loader writes program images and reads back for verification. The block serialises accesses with round-robin priority and tracks read latency, so each requester sees a simple req/gnt/rvalid handshake.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles (legal 1..4)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- c_req  in  1  core request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_W  core read data
- l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader request, same meaning as core
- l_gnt, l_rvalid  out  1  loader grant / read valid
- l_rdata  out  DATA_W  loader read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  read in flight
- owner  out  1  requester of last/current grant (0 core, 1 loader)

## Operation
- States: IDLE, WAIT.
- IDLE, no req: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, no gnt.
- IDLE, one req: that port wins. Both req: winner = priority pointer `prio` (0 core, 1 loader).
- Winner path (combinational, same cycle): gnt=1, mem_en=1, mem_we/addr/wdata = winner's inputs; owner <= winner; prio <= ~winner.
- Winner write: remain IDLE; next arbitration next cycle. No rvalid for writes.
- Winner read: go WAIT, latency counter cnt <= 1.
- WAIT: no grants, mem_en=0; cnt increments each cycle. When cnt==MEM_LAT: assert owner's rvalid for exactly one cycle, rdata = mem_rdata (pass-through), return IDLE.
- Non-owner rvalid always 0. c_rdata/l_rdata = mem_rdata when own rvalid, else 0.
- busy = (state==WAIT).
- Requester rules: hold req, we, addr, wdata stable until gnt. Dropping req before gnt is legal; no access issued. gnt never asserted while WAIT.
- prio only changes on a grant; a lone requester winning repeatedly leaves prio pointing at the other port, so contention always alternates.

## Timing
- Reset (async): state=IDLE, cnt=0, prio=0 (core first), owner=0. All gnt, rvalid, mem_en, mem_we = 0. mem_addr, mem_wdata, rdata = 0.
- Reset during WAIT: pending read discarded, no rvalid issued after reset release.
- Read granted at cycle T: mem_en at T, rvalid at T+MEM_LAT, earliest next gnt at T+MEM_LAT+1.
- Write granted at T: earliest next gnt at T+1; back-to-back writes give 1 access/cycle.
- Requests arriving during WAIT are held (by requester) and arbitrated in the first IDLE cycle.
- cnt width: 3 bits; no wrap for MEM_LAT≤4.

## Test plan
- Reset then idle: reset high mid-cycle → all outputs 0 asynchronously; release with no req → mem_en stays 0.
- Lone core read, MEM_LAT=2: c_req, c_addr=0x10 at T → c_gnt and mem_en at T, mem_addr=0x10; c_rvalid at T+2 with c_rdata=mem_rdata=0xDEADBEEF; l_rvalid stays 0.
- Contention after reset: both read at T → core granted T (prio=0); loader granted T+MEM_LAT+1; third simultaneous pair → core again.
- Back-to-back loader writes: l_req, l_we held 4 cycles with addr 0..3 → l_gnt and mem_we each cycle, mem_addr 0,1,2,3, no l_rvalid.
- Reset during WAIT: core read granted, reset pulsed at T+1 (MEM_LAT=3) → no c_rvalid at T+3; busy=0 after reset.
- Request withdrawn: l_req pulsed one cycle during WAIT, then dropped → no l_gnt, no memory access for the loader.
